// File: rtl/mw8080_mem_pkg.sv
// rtl/mw8080_mem_pkg.sv - shared types and constants for the mw8080 memory subsystem
package mw8080_mem_pkg;

    typedef enum logic [1:0] {BOOT, LOAD, SETTLE, RUN} state_t;
    typedef enum logic [1:0] {RGN_ROM, RGN_RAM, RGN_NONE} region_t;

    localparam int         BANK_BITS     = 11;
    localparam logic [7:0] UNMAPPED_DATA = 8'h00;

endpackage

// File: rtl/mw8080_mem_ctrl_if.sv
// rtl/mw8080_mem_ctrl_if.sv - CPU, video and download bus bundle for mw8080_mem_ctrl
interface mw8080_mem_ctrl_if #(
    parameter int ROM_AW = 14,
    parameter int RAM_AW = 13
);
    logic [15:0]       cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_hold;
    logic [RAM_AW-1:0] vid_addr;
    logic [7:0]        vid_dout;
    logic              dl_active;
    logic              dl_wr;
    logic [ROM_AW-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic [ROM_AW:0]   dl_count;
    logic [7:0]        dl_sum;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_din, vid_addr,
               dl_active, dl_wr, dl_addr, dl_data,
        input  cpu_dout, cpu_hold, vid_dout, dl_count, dl_sum
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_din, vid_addr,
               dl_active, dl_wr, dl_addr, dl_data,
        output cpu_dout, cpu_hold, vid_dout, dl_count, dl_sum
    );
endinterface

// File: rtl/mw8080_dpram.sv
// rtl/mw8080_dpram.sv - dual-port RAM, port A read/write, port B read-only, read-before-write
module mw8080_dpram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          a_we_i,
    input  logic          a_re_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_din_i,
    output logic [DW-1:0] a_dout_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_dout_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] a_dout_q;
    logic [DW-1:0] b_dout_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i) mem_q[a_addr_i] <= a_din_i;
    end

    // Port A output only moves on a read enable so the last read value is held.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            if (a_re_i) a_dout_q <= mem_q[a_addr_i];
            b_dout_q <= mem_q[b_addr_i];
        end
    end

    assign a_dout_o = a_dout_q;
    assign b_dout_o = b_dout_q;
endmodule

// File: rtl/mw8080_mem_ctrl.sv
// rtl/mw8080_mem_ctrl.sv - runtime-loaded ROM, work/video RAM and boot loader FSM for 8080 cores
module mw8080_mem_ctrl
    import mw8080_mem_pkg::*;
#(
    parameter int                 ROM_AW     = 14,
    parameter int                 LO_BANKS   = 4,
    parameter int                 HI_BANKS   = 2,
    parameter logic [4:0]         HI_BASE    = 5'b01010,
    parameter int                 RAM_AW     = 13,
    parameter logic [15-RAM_AW:0] RAM_PAGE   = 3'b001,
    parameter int                 PRELOADED  = 0,
    parameter int                 SETTLE_CYC = 16
) (
    input logic              clk_i,
    input logic              rst_n_i,
    mw8080_mem_ctrl_if.slave bus
);
    localparam int              ROM_BYTES = (LO_BANKS + HI_BANKS) * (1 << BANK_BITS);
    localparam int              IDX_W     = ROM_AW - BANK_BITS;
    localparam int              CW        = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_INIT  = SETTLE_CYC[CW-1:0];
    localparam logic [ROM_AW:0] DL_LIMIT  = ROM_BYTES[ROM_AW:0];
    localparam int              HI_END_I  = int'(HI_BASE) + HI_BANKS;
    localparam logic [5:0]      LO_END    = LO_BANKS[5:0];
    localparam logic [5:0]      HI_LO     = {1'b0, HI_BASE};
    localparam logic [5:0]      HI_END    = HI_END_I[5:0];
    localparam state_t          RST_STATE = (PRELOADED != 0) ? SETTLE : BOOT;
    localparam logic [CW-1:0]   RST_CNT   = (PRELOADED != 0) ? CNT_INIT : {CW{1'b0}};

    generate
        if (ROM_BYTES > (1 << ROM_AW)) begin : g_rom_too_small
            $fatal(1, "mw8080_mem_ctrl: ROM banks exceed physical ROM size");
        end
    endgenerate

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              hold_q;
    logic [ROM_AW:0]   count_q;
    logic [7:0]        sum_q;
    region_t           rgn_q;

    region_t           rgn;
    logic [5:0]        bank;
    logic [5:0]        rom_idx;
    logic [ROM_AW-1:0] cpu_rom_addr;
    logic              cpu_rd_ok, cpu_wr_ok, dl_ok;
    logic [7:0]        rom_dout, ram_dout, rom_b_unused;

    always_comb begin
        bank    = {1'b0, bus.cpu_addr[15:11]};
        rgn     = RGN_NONE;
        rom_idx = '0;
        if (bank < LO_END) begin
            rgn     = RGN_ROM;
            rom_idx = bank;
        end else if (bank >= HI_LO && bank < HI_END) begin
            rgn     = RGN_ROM;
            rom_idx = bank - HI_LO + LO_END;
        end else if (bus.cpu_addr[15:RAM_AW] == RAM_PAGE) begin
            rgn = RGN_RAM;
        end
    end

    assign cpu_rom_addr = {rom_idx[IDX_W-1:0], bus.cpu_addr[BANK_BITS-1:0]};
    // A simultaneous read+write is a write only, so the read path stays idle.
    assign cpu_rd_ok    = (state_q == RUN) && bus.cpu_rd && !bus.cpu_wr;
    assign cpu_wr_ok    = (state_q == RUN) && bus.cpu_wr;
    assign dl_ok        = (state_q == LOAD) && bus.dl_wr && ({1'b0, bus.dl_addr} < DL_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            hold_q  <= 1'b1;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                BOOT: if (bus.dl_active) begin
                    state_q <= LOAD;
                    count_q <= '0;
                    sum_q   <= '0;
                end
                LOAD: begin
                    if (dl_ok) begin
                        count_q <= count_q + (ROM_AW+1)'(1);
                        sum_q   <= sum_q + bus.dl_data;
                    end
                    if (!bus.dl_active) begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_INIT;
                    end
                end
                SETTLE: begin
                    if (bus.dl_active) begin
                        state_q <= LOAD;
                        count_q <= '0;
                        sum_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= RUN;
                        hold_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RUN: if (bus.dl_active) begin
                    state_q <= LOAD;
                    hold_q  <= 1'b1;
                    count_q <= '0;
                    sum_q   <= '0;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)       rgn_q <= RGN_NONE;
        else if (cpu_rd_ok) rgn_q <= rgn;
    end

    // ROM is single ported: the loader owns it in LOAD, the CPU otherwise.
    mw8080_dpram #(.DW(8), .AW(ROM_AW)) u_rom (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .a_we_i   (dl_ok),
        .a_re_i   (cpu_rd_ok && rgn == RGN_ROM),
        .a_addr_i ((state_q == LOAD) ? bus.dl_addr : cpu_rom_addr),
        .a_din_i  (bus.dl_data),
        .a_dout_o (rom_dout),
        .b_addr_i ({ROM_AW{1'b0}}),
        .b_dout_o (rom_b_unused)
    );

    mw8080_dpram #(.DW(8), .AW(RAM_AW)) u_ram (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .a_we_i   (cpu_wr_ok && rgn == RGN_RAM),
        .a_re_i   (cpu_rd_ok && rgn == RGN_RAM),
        .a_addr_i (bus.cpu_addr[RAM_AW-1:0]),
        .a_din_i  (bus.cpu_din),
        .a_dout_o (ram_dout),
        .b_addr_i (bus.vid_addr),
        .b_dout_o (bus.vid_dout)
    );

    always_comb begin
        case (rgn_q)
            RGN_ROM: bus.cpu_dout = rom_dout;
            RGN_RAM: bus.cpu_dout = ram_dout;
            default: bus.cpu_dout = UNMAPPED_DATA;
        endcase
    end

    assign bus.cpu_hold = hold_q;
    assign bus.dl_count = count_q;
    assign bus.dl_sum   = sum_q;
endmodule

// File: tb/tb_mw8080_mem_ctrl.sv
// tb/tb_mw8080_mem_ctrl.sv - scoreboard bench for mw8080_mem_ctrl
module tb_mw8080_mem_ctrl;
    import mw8080_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mw8080_mem_ctrl_if #(.ROM_AW(14), .RAM_AW(13)) ifc ();

    mw8080_mem_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] cpu_q [$];
    logic [7:0] vid_q [$];
    logic       rd_expect = 1'b0;
    logic       vid_expect = 1'b0;
    logic [7:0] cpu_e, vid_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rd_expect) begin
            #1;
            n_cmp++;
            if (cpu_q.size() == 0) begin
                n_err++;
                $display("FAIL cpu_rd: got %0h with no expected value queued", ifc.cpu_dout);
            end else begin
                cpu_e = cpu_q.pop_front();
                if (ifc.cpu_dout !== cpu_e) begin
                    n_err++;
                    $display("FAIL cpu_rd: got %0h want %0h", ifc.cpu_dout, cpu_e);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (vid_expect) begin
            #1;
            n_cmp++;
            if (vid_q.size() == 0) begin
                n_err++;
                $display("FAIL vid_rd: got %0h with no expected value queued", ifc.vid_dout);
            end else begin
                vid_e = vid_q.pop_front();
                if (ifc.vid_dout !== vid_e) begin
                    n_err++;
                    $display("FAIL vid_rd: got %0h want %0h", ifc.vid_dout, vid_e);
                end
            end
        end
    end

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] e);
        cpu_q.push_back(e);
        ifc.cpu_addr = a;
        ifc.cpu_rd   = 1'b1;
        rd_expect    = 1'b1;
        @(negedge clk);
        ifc.cpu_rd   = 1'b0;
        rd_expect    = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        ifc.cpu_addr = a;
        ifc.cpu_din  = d;
        ifc.cpu_wr   = 1'b1;
        @(negedge clk);
        ifc.cpu_wr   = 1'b0;
    endtask

    task automatic vid_read(input logic [12:0] a, input logic [7:0] e);
        vid_q.push_back(e);
        ifc.vid_addr = a;
        vid_expect   = 1'b1;
        @(negedge clk);
        vid_expect   = 1'b0;
    endtask

    task automatic dl_byte(input logic [13:0] a, input logic [7:0] d);
        ifc.dl_wr   = 1'b1;
        ifc.dl_addr = a;
        ifc.dl_data = d;
        @(negedge clk);
        ifc.dl_wr   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.cpu_addr = '0; ifc.cpu_rd = 0; ifc.cpu_wr = 0; ifc.cpu_din = '0;
        ifc.vid_addr = '0; ifc.dl_active = 0; ifc.dl_wr = 0; ifc.dl_addr = '0; ifc.dl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_hold", ifc.cpu_hold, 1);
        check("rst_cpu_dout", ifc.cpu_dout, 0);
        check("rst_vid_dout", ifc.vid_dout, 0);
        check("rst_dl_count", ifc.dl_count, 0);
        check("rst_dl_sum", ifc.dl_sum, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("boot_hold", ifc.cpu_hold, 1);
        check("boot_state", 32'(dut.state_q), 32'(BOOT));
        ifc.cpu_addr = 16'h0005; ifc.cpu_rd = 1'b1;
        @(negedge clk);
        ifc.cpu_rd = 1'b0;
        @(negedge clk);
        check("boot_rd_ignored", ifc.cpu_dout, 0);

        ifc.dl_active = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 'h3000; i++) begin
            ifc.dl_wr = 1'b1; ifc.dl_addr = 14'(i); ifc.dl_data = 8'(i);
            @(negedge clk);
        end
        ifc.dl_wr = 1'b0;
        check("dl_count_full", ifc.dl_count, 'h3000);
        check("dl_sum_full", ifc.dl_sum, 8'h00);
        ifc.dl_active = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (ifc.cpu_hold && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("settle_cycles", n, 17);
        @(negedge clk);

        cpu_read(16'h0005, 8'h05);
        cpu_read(16'h5001, 8'h01);
        cpu_read(16'h4000, 8'h00);
        cpu_read(16'h5FFF, 8'hFF);
        cpu_read(16'h6000, 8'h00);
        cpu_write(16'h2400, 8'hA5);
        cpu_read(16'h2400, 8'hA5);
        cpu_write(16'h0100, 8'h77);
        cpu_read(16'h0100, 8'h00);
        vid_read(13'h0400, 8'hA5);

        ifc.cpu_addr = 16'h2400; ifc.cpu_din = 8'h5A; ifc.cpu_rd = 1'b1; ifc.cpu_wr = 1'b1;
        @(negedge clk);
        ifc.cpu_rd = 1'b0; ifc.cpu_wr = 1'b0;
        check("rdwr_dout_held", ifc.cpu_dout, 8'h00);
        cpu_read(16'h2400, 8'h5A);
        repeat (3) @(negedge clk);
        check("dout_hold_idle", ifc.cpu_dout, 8'h5A);

        cpu_write(16'h2010, 8'h11);
        vid_q.push_back(8'h11);
        vid_q.push_back(8'h3C);
        ifc.cpu_addr = 16'h2010; ifc.cpu_din = 8'h3C; ifc.cpu_wr = 1'b1;
        ifc.vid_addr = 13'h0010; vid_expect = 1'b1;
        @(negedge clk);
        ifc.cpu_wr = 1'b0;
        @(negedge clk);
        vid_expect = 1'b0;

        ifc.dl_active = 1'b1;
        @(posedge clk); #1;
        check("run_to_load_hold", ifc.cpu_hold, 1);
        @(negedge clk);
        for (int i = 0; i < 100; i++) dl_byte(14'(i), 8'(i) ^ 8'hFF);
        check("partial_count", ifc.dl_count, 100);
        rst_n = 1'b0; ifc.dl_active = 1'b0;
        #1;
        check("midload_rst_count", ifc.dl_count, 0);
        check("midload_rst_hold", ifc.cpu_hold, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midload_rst_state", 32'(dut.state_q), 32'(BOOT));

        ifc.dl_active = 1'b1;
        repeat (2) @(negedge clk);
        dl_byte(14'h0010, 8'h21);
        dl_byte(14'h0011, 8'h42);
        dl_byte(14'h3800, 8'h55);
        dl_byte(14'h0012, 8'h63);
        dl_byte(14'h0013, 8'h84);
        check("oor_count", ifc.dl_count, 4);
        check("oor_sum", ifc.dl_sum, 8'h4A);
        ifc.dl_active = 1'b0;
        repeat (20) @(negedge clk);
        check("rerun_hold", ifc.cpu_hold, 0);
        cpu_read(16'h0012, 8'h63);
        cpu_read(16'h0014, 8'hEB);
        cpu_read(16'h0080, 8'h80);

        dl_byte(14'h0005, 8'hEE);
        cpu_read(16'h0005, 8'hFA);
        check("run_dl_ignored_count", ifc.dl_count, 4);

        repeat (2) @(negedge clk);
        check("queues_drained", cpu_q.size() + vid_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
